aib_calib_slave_ctrl: RTL

//  Slave-side AIB calibration controller for N channels with per-channel enable mask, timeouts and bounded retry.

---
 rtl/aib_calib_pkg.sv | 23 ++
 rtl/aib_calib_timer.sv | 28 ++
 rtl/aib_calib_slave_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/aib_calib_pkg.sv
// Shared types and default sizing for the AIB slave calibration controller.
package aib_calib_pkg;

    localparam int DEF_CHNL_NUM   = 24;
    localparam int DEF_TMO_W      = 16;
    localparam int DEF_TMO_CYC    = 50000;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_MAX_RETRY  = 3;
    localparam int RETRY_W        = 2;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_READY    = 4'd1,
        ST_CONFIG   = 4'd2,
        ST_PHADJ    = 4'd3,
        ST_WAIT_REQ = 4'd4,
        ST_SETTLE   = 4'd5,
        ST_RESPOND  = 4'd6,
        ST_LINKUP   = 4'd7,
        ST_ERROR    = 4'd8
    } calib_state_t;

endpackage

// File: rtl/aib_calib_timer.sv
// Loadable down-counter. Once loaded with V, expired rises in the V-th enabled cycle,
// so a state guarded by it lasts exactly V cycles.
module aib_calib_timer #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMO_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TMO_W'(1);
        end
    end

    assign expired = (cnt_q <= TMO_W'(1));

endmodule

// File: rtl/aib_calib_slave_ctrl.sv
// Slave-side AIB calibration FSM with channel mask, timeouts and bounded retry.
// Define AIB_CALIB_RELOCK_EN to drop back to WAIT_REQ when a master request falls in LINKUP.
module aib_calib_slave_ctrl
    import aib_calib_pkg::*;
#(
    parameter int TOTAL_CHNL_NUM = DEF_CHNL_NUM,
    parameter int TMO_W          = DEF_TMO_W,
    parameter int TMO_CYC        = DEF_TMO_CYC,
    parameter int SETTLE_CYC     = DEF_SETTLE_CYC,
    parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      calib_en,
    input  logic [TOTAL_CHNL_NUM-1:0] chnl_mask,
    input  logic [TOTAL_CHNL_NUM-1:0] ms_rx_dcc_dll_lock_req,
    input  logic [TOTAL_CHNL_NUM-1:0] ms_tx_dcc_dll_lock_req,
    output logic                      cfg_start,
    input  logic                      cfg_done,
    output logic                      phadj_start,
    input  logic                      phadj_done,
    output logic                      i_conf_done,
    output logic [TOTAL_CHNL_NUM-1:0] ns_mac_rdy,
    output logic [TOTAL_CHNL_NUM-1:0] ns_adapter_rstn,
    output logic [TOTAL_CHNL_NUM-1:0] sl_rx_dcc_dll_lock_req,
    output logic [TOTAL_CHNL_NUM-1:0] sl_tx_dcc_dll_lock_req,
    output logic [TOTAL_CHNL_NUM-1:0] sl_tx_transfer_en,
    output logic [TOTAL_CHNL_NUM-1:0] sl_rx_transfer_en,
    output logic                      calib_done,
    output logic                      calib_err,
    output logic [RETRY_W-1:0]        retry_cnt
);

    localparam logic [TMO_W-1:0]   TMO_VAL    = TMO_W'(TMO_CYC);
    localparam logic [TMO_W-1:0]   SETTLE_VAL = TMO_W'(SETTLE_CYC);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    calib_state_t              state_q, state_d;
    logic [TOTAL_CHNL_NUM-1:0] mask_q, mask_d;
    logic [TOTAL_CHNL_NUM-1:0] mac_rdy_q, mac_rdy_d;
    logic [TOTAL_CHNL_NUM-1:0] slv_q, slv_d;
    logic [RETRY_W-1:0]        retry_q, retry_d;
    logic                      conf_done_q, conf_done_d;
    logic                      cfg_start_q, cfg_start_d;
    logic                      phadj_start_q, phadj_start_d;

    logic             tmr_load, tmr_en, tmr_exp, tmo_hit, req_match;
    logic [TMO_W-1:0] tmr_val;

    // Unmasked channels are don't-care; an empty mask never matches.
    assign req_match = ((ms_rx_dcc_dll_lock_req & ms_tx_dcc_dll_lock_req & mask_q) == mask_q)
                       && (mask_q != '0);

    assign tmr_en = (state_q == ST_CONFIG) || (state_q == ST_PHADJ) ||
                    (state_q == ST_WAIT_REQ) || (state_q == ST_SETTLE);

    aib_calib_timer #(.TMO_W(TMO_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_exp)
    );

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        mac_rdy_d     = mac_rdy_q;
        slv_d         = slv_q;
        retry_d       = retry_q;
        conf_done_d   = conf_done_q;
        cfg_start_d   = 1'b0;
        phadj_start_d = 1'b0;
        tmr_load      = 1'b0;
        tmr_val       = TMO_VAL;
        tmo_hit       = 1'b0;

        if (!calib_en) begin
            state_d     = ST_IDLE;
            mac_rdy_d   = '0;
            slv_d       = '0;
            retry_d     = '0;
            conf_done_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mask_d  = chnl_mask;
                    retry_d = '0;
                    state_d = ST_READY;
                end
                ST_READY: begin
                    conf_done_d = 1'b1;
                    mac_rdy_d   = mask_q;
                    cfg_start_d = 1'b1;
                    tmr_load    = 1'b1;
                    state_d     = ST_CONFIG;
                end
                // Done is checked before expiry so a same-cycle done wins.
                ST_CONFIG: begin
                    if (cfg_done) begin
                        phadj_start_d = 1'b1;
                        tmr_load      = 1'b1;
                        state_d       = ST_PHADJ;
                    end else begin
                        tmo_hit = tmr_exp;
                    end
                end
                ST_PHADJ: begin
                    if (phadj_done) begin
                        tmr_load = 1'b1;
                        state_d  = ST_WAIT_REQ;
                    end else begin
                        tmo_hit = tmr_exp;
                    end
                end
                ST_WAIT_REQ: begin
                    if (req_match) begin
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_VAL;
                        state_d  = ST_SETTLE;
                    end else begin
                        tmo_hit = tmr_exp;
                    end
                end
                ST_SETTLE: begin
                    if (!req_match) begin
                        tmr_load = 1'b1;
                        state_d  = ST_WAIT_REQ;
                    end else if (tmr_exp) begin
                        state_d = ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    slv_d   = mask_q;
                    state_d = ST_LINKUP;
                end
                ST_LINKUP: begin
`ifdef AIB_CALIB_RELOCK_EN
                    if (!req_match) begin
                        slv_d    = '0;
                        tmr_load = 1'b1;
                        state_d  = ST_WAIT_REQ;
                    end
`endif
                end
                ST_ERROR: begin
                    slv_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (tmo_hit) begin
                slv_d = '0;
                if (retry_q < RETRY_MAX) begin
                    retry_d     = retry_q + RETRY_W'(1);
                    cfg_start_d = 1'b1;
                    tmr_load    = 1'b1;
                    state_d     = ST_CONFIG;
                end else begin
                    state_d = ST_ERROR;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            mac_rdy_q     <= '0;
            slv_q         <= '0;
            retry_q       <= '0;
            conf_done_q   <= 1'b0;
            cfg_start_q   <= 1'b0;
            phadj_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            mac_rdy_q     <= mac_rdy_d;
            slv_q         <= slv_d;
            retry_q       <= retry_d;
            conf_done_q   <= conf_done_d;
            cfg_start_q   <= cfg_start_d;
            phadj_start_q <= phadj_start_d;
        end
    end

    assign cfg_start              = cfg_start_q;
    assign phadj_start            = phadj_start_q;
    assign i_conf_done            = conf_done_q;
    assign ns_mac_rdy             = mac_rdy_q;
    assign ns_adapter_rstn        = slv_q;
    assign sl_rx_dcc_dll_lock_req = slv_q;
    assign sl_tx_dcc_dll_lock_req = slv_q;
    assign sl_tx_transfer_en      = slv_q;
    assign sl_rx_transfer_en      = slv_q;
    assign calib_done             = (state_q == ST_LINKUP);
    assign calib_err              = (state_q == ST_ERROR);
    assign retry_cnt              = retry_q;

endmodule
